// File: rtl/xilly_stream_pkg.sv
// Shared types and helpers for the Xillybus read-stream FIFO: control state
// encoding, the default channel width and the pointer-difference helper.
package xilly_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } xilly_state_e;

    localparam int XILLY_WIDTH = 32;
    localparam int PTR_MAX_W   = 32;

    // Modular difference; callers truncate to their own pointer width, which
    // keeps the result correct across pointer wrap.
    function automatic logic [PTR_MAX_W-1:0] ptr_diff(
        input logic [PTR_MAX_W-1:0] wr_ptr,
        input logic [PTR_MAX_W-1:0] rd_ptr
    );
        return wr_ptr - rd_ptr;
    endfunction

endpackage

// File: rtl/xilly_sdp_ram.sv
// Simple dual-port RAM with one write port and one registered read port,
// written so synthesis maps it onto block RAM.
module xilly_sdp_ram #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the storage array has no reset; only the output register is
    // cleared, which keeps the array mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/xilly_rd_stream_fifo.sv
// Accelerator-to-Xillybus read-channel FIFO with EOF generation and flush on
// close. Optional statistics outputs are enabled by XILLY_RD_STREAM_FIFO_STATS_EN.
module xilly_rd_stream_fifo
    import xilly_stream_pkg::*;
#(
    parameter int WIDTH      = XILLY_WIDTH,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic                  user_r_rden,
    output logic [WIDTH-1:0]      user_r_data,
    output logic                  user_r_empty,
    output logic                  user_r_eof,
    input  logic                  user_r_open,
    output logic [DEPTH_LOG2:0]   fill_level
`ifdef XILLY_RD_STREAM_FIFO_STATS_EN
    ,
    output logic [31:0]           word_count,
    output logic                  stream_done
`endif
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    xilly_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic             empty_q, empty_d;
    logic             eof_q, eof_d;

    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] count_d;
    logic             full;
    logic             push;
    logic             pop;
    logic             flush;

    assign count_q  = PTR_W'(ptr_diff(PTR_MAX_W'(wr_ptr_q), PTR_MAX_W'(rd_ptr_q)));
    assign full     = (count_q == DEPTH);
    assign in_ready = (state_q == STREAM) && !full;
    assign push     = in_valid && in_ready;
    assign pop      = user_r_rden && !empty_q;
    assign flush    = !user_r_open;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case (state_q)
            IDLE:    if (user_r_open) state_d = STREAM;
            STREAM:  if (push && in_last) state_d = DRAIN;
            DRAIN:   state_d = DRAIN;
            default: state_d = IDLE;
        endcase

        // A close discards everything, including a word pushed this cycle.
        if (flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        count_d = PTR_W'(ptr_diff(PTR_MAX_W'(wr_ptr_d), PTR_MAX_W'(rd_ptr_d)));
        fill_d  = count_d;
        empty_d = (count_d == '0);
        eof_d   = (state_d == DRAIN) && (count_d == '0);
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            empty_q  <= 1'b1;
            eof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            empty_q  <= empty_d;
            eof_q    <= eof_d;
        end
    end

    // The read register still loads on a pop that coincides with a close.
    xilly_sdp_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (bus_clk),
        .rst     (bus_rst),
        .wr_en   (push && user_r_open),
        .wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data (user_r_data)
    );

    assign user_r_empty = empty_q;
    assign user_r_eof   = eof_q;
    assign fill_level   = fill_q;

`ifdef XILLY_RD_STREAM_FIFO_STATS_EN
    logic [31:0] word_count_q, word_count_d;
    logic        stream_done_q, stream_done_d;

    always_comb begin
        word_count_d  = word_count_q;
        stream_done_d = stream_done_q | eof_d;
        if (pop && (word_count_q != 32'hFFFF_FFFF)) begin
            word_count_d = word_count_q + 32'd1;
        end
        if (flush) begin
            word_count_d  = '0;
            stream_done_d = 1'b0;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            word_count_q  <= '0;
            stream_done_q <= 1'b0;
        end else begin
            word_count_q  <= word_count_d;
            stream_done_q <= stream_done_d;
        end
    end

    assign word_count  = word_count_q;
    assign stream_done = stream_done_q;
`endif

endmodule

// File: tb/tb_xilly_rd_stream_fifo.sv
// Bench for xilly_rd_stream_fifo: directed scenarios plus randomized streams,
// checked every cycle against a queue-based reference model.
module tb_xilly_rd_stream_fifo;

    localparam int W     = 32;
    localparam int DL2   = 3;
    localparam int DEPTH = 1 << DL2;

    localparam int M_IDLE   = 0;
    localparam int M_STREAM = 1;
    localparam int M_DRAIN  = 2;

    logic           bus_clk = 1'b0;
    logic           bus_rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic           in_ready;
    logic           user_r_rden = 1'b0;
    logic [W-1:0]   user_r_data;
    logic           user_r_empty;
    logic           user_r_eof;
    logic           user_r_open = 1'b0;
    logic [DL2:0]   fill_level;
`ifdef XILLY_RD_STREAM_FIFO_STATS_EN
    logic [31:0]    word_count;
    logic           stream_done;
`endif

    xilly_rd_stream_fifo #(
        .WIDTH      (W),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .bus_clk      (bus_clk),
        .bus_rst      (bus_rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .user_r_rden  (user_r_rden),
        .user_r_data  (user_r_data),
        .user_r_empty (user_r_empty),
        .user_r_eof   (user_r_eof),
        .user_r_open  (user_r_open),
        .fill_level   (fill_level)
`ifdef XILLY_RD_STREAM_FIFO_STATS_EN
        ,
        .word_count   (word_count),
        .stream_done  (stream_done)
`endif
    );

    always #5 bus_clk = ~bus_clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words stored, words already read, stream state.
    logic [W-1:0] m_fifo[$];
    logic [W-1:0] m_data  = '0;
    int           m_state = M_IDLE;
    bit           m_eof   = 1'b0;
    logic [31:0]  m_wc    = '0;
    bit           m_done  = 1'b0;

    task automatic model_step();
        bit do_pop;
        bit do_push;
        bit do_flush;
        if (bus_rst) begin
            m_fifo.delete();
            m_data  = '0;
            m_state = M_IDLE;
            m_eof   = 1'b0;
            m_wc    = '0;
            m_done  = 1'b0;
        end else begin
            do_pop   = user_r_rden && (m_fifo.size() != 0);
            do_push  = in_valid && (m_state == M_STREAM) && (m_fifo.size() < DEPTH);
            do_flush = !user_r_open;
            if (do_pop) begin
                m_data = m_fifo.pop_front();
                if (m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
            end
            if (do_push) m_fifo.push_back(in_data);
            if (do_flush) begin
                m_fifo.delete();
                m_state = M_IDLE;
                m_wc    = '0;
                m_done  = 1'b0;
            end else if (m_state == M_IDLE) begin
                m_state = M_STREAM;
            end else if (m_state == M_STREAM && do_push && in_last) begin
                m_state = M_DRAIN;
            end
            m_eof = (m_state == M_DRAIN) && (m_fifo.size() == 0);
            if (!do_flush && m_eof) m_done = 1'b1;
        end
    endtask

    // Monitor: compare outputs mid-cycle, then advance the model over the next edge.
    always @(negedge bus_clk) begin
        if (mon_en) begin
            check("in_ready", 32'(in_ready), 32'((m_state == M_STREAM) && (m_fifo.size() < DEPTH)));
            check("rd_data", user_r_data, m_data);
            check("empty", 32'(user_r_empty), 32'(m_fifo.size() == 0));
            check("eof", 32'(user_r_eof), 32'(m_eof));
            check("fill_level", 32'(fill_level), 32'(m_fifo.size()));
`ifdef XILLY_RD_STREAM_FIFO_STATS_EN
            check("word_count", word_count, m_wc);
            check("stream_done", 32'(stream_done), 32'(m_done));
`endif
        end
        model_step();
    end

    task automatic step(output bit acc);
        @(negedge bus_clk);
        acc = in_valid && in_ready;
        @(posedge bus_clk);
        #1;
    endtask

    task automatic tick(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic last);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 200 && !acc; i++) step(acc);
        check("push_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic reopen();
        user_r_open = 1'b0;
        user_r_rden = 1'b0;
        in_valid    = 1'b0;
        tick(2);
        user_r_open = 1'b1;
        tick(1);
    endtask

    task automatic random_stream(input int n, input bit allow_abort);
        int  sent;
        int  cyc;
        bit  aborted;
        bit  acc;
        sent    = 0;
        cyc     = 0;
        aborted = 1'b0;
        reopen();
        while (sent < n && !aborted && cyc < 5000) begin
            in_valid    = ($urandom % 4) != 0;
            in_data     = $urandom;
            in_last     = (sent == n - 1);
            user_r_rden = ($urandom % 2) != 0;
            if (allow_abort && ($urandom % 80) == 0) begin
                user_r_open = 1'b0;
                aborted     = 1'b1;
            end
            step(acc);
            if (acc && !aborted) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!aborted) check("rand_stream_sent", sent, n);
        user_r_rden = 1'b1;
        tick(DEPTH + 4);
        user_r_rden = 1'b0;
    endtask

    initial begin
        bit acc;
        // Reset
        tick(2);
        mon_en = 1'b1;
        check("rst_empty", 32'(user_r_empty), 32'd1);
        check("rst_fill", 32'(fill_level), 32'd0);
        bus_rst = 1'b0;

        // Basic transfer with rden held
        user_r_open = 1'b1;
        tick(1);
        user_r_rden = 1'b1;
        push_word(32'h11, 1'b0);
        push_word(32'h22, 1'b0);
        push_word(32'h33, 1'b1);
        check("basic_ready_after_last", 32'(in_ready), 32'd0);
        tick(3);
        check("basic_last_data", user_r_data, 32'h33);
        check("basic_eof", 32'(user_r_eof), 32'd1);
        check("basic_empty", 32'(user_r_empty), 32'd1);
        user_r_rden = 1'b0;

        // Full buffer
        reopen();
        for (int i = 0; i < DEPTH; i++) push_word(32'h100 + i, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h1FF;
        tick(3);
        check("full_fill", 32'(fill_level), 32'(DEPTH));
        check("full_ready", 32'(in_ready), 32'd0);
        user_r_rden = 1'b1;
        tick(1);
        user_r_rden = 1'b0;
        check("full_pop_data", user_r_data, 32'h100);
        check("ready_after_pop", 32'(in_ready), 32'd1);
        push_word(32'h1FF, 1'b0);
        check("full_refill", 32'(fill_level), 32'(DEPTH));
        user_r_rden = 1'b1;
        tick(DEPTH + 3);
        check("full_drain_last", user_r_data, 32'h1FF);
        user_r_rden = 1'b0;

        // Simultaneous push and pop at count 1
        push_word(32'hA0, 1'b0);
        for (int i = 1; i < 3; i++) begin
            in_valid    = 1'b1;
            in_data     = 32'hA0 + i;
            user_r_rden = 1'b1;
            step(acc);
            check("cnt1_accept", 32'(acc), 32'd1);
            check("cnt1_fill", 32'(fill_level), 32'd1);
            check("cnt1_data", user_r_data, 32'hA0 + i - 1);
        end
        in_valid = 1'b0;
        tick(2);
        check("cnt1_final", user_r_data, 32'hA2);
        user_r_rden = 1'b0;

        // Mid-stream close, with a push and pop in the closing cycle
        for (int i = 0; i < 5; i++) push_word(32'hB0 + i, 1'b0);
        check("close_pre_fill", 32'(fill_level), 32'd5);
        user_r_open = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'hEE;
        user_r_rden = 1'b1;
        tick(1);
        in_valid    = 1'b0;
        user_r_rden = 1'b0;
        check("close_fill", 32'(fill_level), 32'd0);
        check("close_empty", 32'(user_r_empty), 32'd1);
        check("close_eof", 32'(user_r_eof), 32'd0);
        check("close_ready", 32'(in_ready), 32'd0);
        check("close_pop_data", user_r_data, 32'hB0);
        tick(1);
        user_r_open = 1'b1;
        tick(1);
        push_word(32'hAB, 1'b1);
        user_r_rden = 1'b1;
        tick(4);
        check("reopen_data", user_r_data, 32'hAB);
        check("reopen_eof", 32'(user_r_eof), 32'd1);
        user_r_rden = 1'b0;

        // Single-word stream
        reopen();
        push_word(32'h5A, 1'b1);
        tick(1);
        check("single_eof_before_pop", 32'(user_r_eof), 32'd0);
        user_r_rden = 1'b1;
        tick(1);
        user_r_rden = 1'b0;
        check("single_data", user_r_data, 32'h5A);
        check("single_eof", 32'(user_r_eof), 32'd1);

        // Randomized streams, some aborted by a close
        for (int s = 0; s < 8; s++) random_stream($urandom_range(1, 30), 1'b1);

        // Long stream for the pop counter
        random_stream(300, 1'b0);
`ifdef XILLY_RD_STREAM_FIFO_STATS_EN
        check("stats_word_count", word_count, 32'd300);
        check("stats_done", 32'(stream_done), 32'd1);
`endif
        user_r_open = 1'b0;
        tick(1);
`ifdef XILLY_RD_STREAM_FIFO_STATS_EN
        check("stats_count_clear", word_count, 32'd0);
        check("stats_done_clear", 32'(stream_done), 32'd0);
`endif
        check("end_eof_clear", 32'(user_r_eof), 32'd0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
